gem_link_ctrl: RTL and testbench

GEM_LINK_CTRL -- requirements
Module: gem_link_ctrl

---
 rtl/gem_link_pkg.sv | 29 ++
 rtl/gem_frame_sep_gen.sv | 68 ++++++
 rtl/gem_link_ctrl.sv | 123 ++++++++++++
 tb/tb_gem_link_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gem_link_pkg.sv
// Shared types and constants for the GEM trigger link controller.
package gem_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
   } link_state_e;

   localparam logic [7:0]  K_BC = 8'hBC;
   localparam logic [7:0]  K_F7 = 8'hF7;
   localparam logic [7:0]  K_FB = 8'hFB;
   localparam logic [7:0]  K_FD = 8'hFD;
   localparam logic [7:0]  K_FC = 8'hFC;
   localparam logic [7:0]  K_50 = 8'h50;

   localparam logic [15:0] COMMA_WORD    = 16'h50BC;
   localparam logic [3:0]  COMMA_CHARISK = 4'b0101;

   function automatic logic [7:0] sep_code(input logic [1:0] idx);
      case (idx)
         2'd0:    sep_code = K_BC;
         2'd1:    sep_code = K_F7;
         2'd2:    sep_code = K_FB;
         default: sep_code = K_FD;
      endcase
   endfunction

endpackage

// File: rtl/gem_frame_sep_gen.sv
// Frame separator generator: K-code sequence index, SEP_HOLD frame counter and separator mux.
// Build macro GEM_BC0_MARKER_EN: BC0 on a DATA boundary emits 50 and restarts the sequence at BC.
module gem_frame_sep_gen
   import gem_link_pkg::*;
#(
   parameter int SEP_HOLD = 2
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       data_now,
   input  logic       data_next,
   input  logic       boundary,
   input  logic       overflow,
   input  logic       bc0,
   output logic [7:0] frm_sep
);

   localparam logic [2:0] HOLD_LAST = 3'(SEP_HOLD - 1);

   logic [1:0] idx_q, idx_d;
   logic [2:0] hold_q, hold_d;
   logic       mark;

`ifdef GEM_BC0_MARKER_EN
   assign mark = data_now & boundary & bc0;
`else
   logic unused_bc0;
   assign unused_bc0 = bc0;
   assign mark       = 1'b0;
`endif

   always_comb begin
      idx_d  = idx_q;
      hold_d = hold_q;
      // the sequence only runs while staying in DATA; entry and exit both restart it at BC
      if (!data_now || !data_next || mark) begin
         idx_d  = '0;
         hold_d = '0;
      end else if (boundary) begin
         if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            idx_d  = idx_q + 2'd1;
         end else begin
            hold_d = hold_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         hold_q <= '0;
      end else begin
         idx_q  <= idx_d;
         hold_q <= hold_d;
      end
   end

   always_comb begin
      frm_sep = sep_code(idx_q);
      if (mark) begin
         frm_sep = K_50;
      end else if (overflow) begin
         frm_sep = K_FC;
      end
   end

endmodule

// File: rtl/gem_link_ctrl.sv
// GEM trigger link controller: comma sync sequencing, separator K-codes, test-pattern and latency strobes.
// Build macro GEM_BC0_MARKER_EN enables the BC0 marker separator inside gem_frame_sep_gen.
//
// state | meaning
// IDLE  | transceiver not ready, sending commas
// SYNC  | sending SYNC_FRAMES complete comma frames
// DATA  | link up, payload with frame separators
module gem_link_ctrl
   import gem_link_pkg::*;
#(
   parameter int SYNC_FRAMES = 16,
   parameter int SEP_HOLD    = 2
) (
   input  logic       TRG_CLK80,
   input  logic       TRG_RST_N,
   input  logic       TX_READY,
   input  logic       RESYNC,
   input  logic       ENA_TEST_PAT,
   input  logic       GEM_OVERFLOW,
   input  logic       BC0,
   output logic       TX_WORD_SEL,
   output logic       TX_COMMA,
   output logic [7:0] FRM_SEP,
   output logic       TEST_PAT_ACTIVE,
   output logic       LINK_UP,
   output logic       LTNCY_TRIG
);

   localparam logic [7:0] SYNC_LAST = 8'(SYNC_FRAMES - 1);

   link_state_e state_q, state_d;
   logic        phase_q, phase_d;
   logic [7:0]  sync_cnt_q, sync_cnt_d;
   logic        resync_q, resync_d;
   logic        test_pat_q, test_pat_d;
   logic [7:0]  lat_q, lat_d;
   logic        trig_q, trig_d;
   logic        boundary;
   logic        data_now, data_next;

   assign boundary  = ~phase_q;
   assign data_now  = (state_q == ST_DATA);
   assign data_next = (state_d == ST_DATA);

   always_comb begin
      state_d    = state_q;
      sync_cnt_d = '0;
      resync_d   = 1'b0;
      phase_d    = ~phase_q;
      test_pat_d = boundary ? ENA_TEST_PAT : test_pat_q;
      lat_d      = data_now ? lat_q + 8'd1 : 8'd0;
      trig_d     = data_now && (lat_q == 8'd0);
      if (!TX_READY) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (boundary) state_d = ST_SYNC;
            end
            ST_SYNC: begin
               sync_cnt_d = sync_cnt_q;
               if (boundary) begin
                  if (sync_cnt_q == SYNC_LAST) begin
                     state_d    = ST_DATA;
                     sync_cnt_d = '0;
                  end else begin
                     sync_cnt_d = sync_cnt_q + 8'd1;
                  end
               end
            end
            ST_DATA: begin
               // a request seen mid-frame waits for the boundary so no frame is split
               if (boundary) begin
                  if (resync_q || RESYNC) state_d = ST_SYNC;
               end else begin
                  resync_d = resync_q | RESYNC;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
      if (!TRG_RST_N) begin
         state_q    <= ST_IDLE;
         phase_q    <= 1'b1;
         sync_cnt_q <= '0;
         resync_q   <= 1'b0;
         test_pat_q <= 1'b0;
         lat_q      <= '0;
         trig_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         sync_cnt_q <= sync_cnt_d;
         resync_q   <= resync_d;
         test_pat_q <= test_pat_d;
         lat_q      <= lat_d;
         trig_q     <= trig_d;
      end
   end

   gem_frame_sep_gen #(
      .SEP_HOLD (SEP_HOLD)
   ) u_sep (
      .clk_sys   (TRG_CLK80),
      .rst_n     (TRG_RST_N),
      .data_now  (data_now),
      .data_next (data_next),
      .boundary  (boundary),
      .overflow  (GEM_OVERFLOW),
      .bc0       (BC0),
      .frm_sep   (FRM_SEP)
   );

   assign TX_WORD_SEL     = phase_q;
   assign TX_COMMA        = ~data_now;
   assign LINK_UP         = data_now;
   assign TEST_PAT_ACTIVE = test_pat_q;
   assign LTNCY_TRIG      = trig_q;

endmodule

// File: tb/tb_gem_link_ctrl.sv
// Bench for gem_link_ctrl: frame-level reference model checked every cycle plus directed literal checks.
module tb_gem_link_ctrl;

   localparam int SYNC_FRAMES = 16;
   localparam int SEP_HOLD    = 2;
   localparam int M_IDLE = 0, M_SYNC = 1, M_DATA = 2;

   logic       clk, rst_n, tx_ready, resync, ena_tp, ovf, bc0;
   logic       word_sel, comma, tp_act, link_up, trig;
   logic [7:0] frm_sep;

   gem_link_ctrl #(.SYNC_FRAMES(SYNC_FRAMES), .SEP_HOLD(SEP_HOLD)) dut (
      .TRG_CLK80       (clk),
      .TRG_RST_N       (rst_n),
      .TX_READY        (tx_ready),
      .RESYNC          (resync),
      .ENA_TEST_PAT    (ena_tp),
      .GEM_OVERFLOW    (ovf),
      .BC0             (bc0),
      .TX_WORD_SEL     (word_sel),
      .TX_COMMA        (comma),
      .FRM_SEP         (frm_sep),
      .TEST_PAT_ACTIVE (tp_act),
      .LINK_UP         (link_up),
      .LTNCY_TRIG      (trig)
   );

   int   n_vec = 0, n_err = 0;
   bit   chk_en = 0;
   int   n;
   logic [7:0] sep_tab [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};
   logic [7:0] seq_exp [9] = '{8'hBC, 8'hBC, 8'hF7, 8'hF7, 8'hFB, 8'hFB, 8'hFD, 8'hFD, 8'hBC};

   // reference model state
   int m_mode, m_sync_cyc, m_data_cyc, m_seq_frames, nm;
   bit m_phase, m_pend, m_tp, m_trig, bnd, mk;

   task automatic chk(input string nm_s, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm_s, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_sep();
      logic mark_now;
`ifdef GEM_BC0_MARKER_EN
      mark_now = (m_mode == M_DATA) && !m_phase && bc0;
`else
      mark_now = 1'b0;
`endif
      if (mark_now) return 8'h50;
      if (ovf)      return 8'hFC;
      return sep_tab[(m_seq_frames / SEP_HOLD) % 4];
   endfunction

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_mode = M_IDLE; m_phase = 1; m_sync_cyc = 0; m_data_cyc = 0;
         m_seq_frames = 0; m_pend = 0; m_tp = 0; m_trig = 0;
      end else begin
         bnd = !m_phase;
`ifdef GEM_BC0_MARKER_EN
         mk = bc0;
`else
         mk = 0;
`endif
         m_trig = (m_mode == M_DATA) && (m_data_cyc % 256 == 0);
         if (bnd) m_tp = ena_tp;
         nm = m_mode;
         if (!tx_ready) nm = M_IDLE;
         else if (m_mode == M_IDLE && bnd) nm = M_SYNC;
         else if (m_mode == M_SYNC && bnd && m_sync_cyc == 2 * SYNC_FRAMES - 1) nm = M_DATA;
         else if (m_mode == M_DATA && bnd && (m_pend || resync)) nm = M_SYNC;
         if (m_mode == M_DATA && nm == M_DATA) begin
            m_data_cyc++;
            if (bnd) m_seq_frames = mk ? 0 : m_seq_frames + 1;
            m_pend = !bnd && (m_pend || resync);
         end else begin
            m_data_cyc = 0; m_seq_frames = 0; m_pend = 0;
         end
         m_sync_cyc = (m_mode == M_SYNC && nm == M_SYNC) ? m_sync_cyc + 1 : 0;
         m_mode  = nm;
         m_phase = !m_phase;
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("word_sel", word_sel, m_phase);
         chk("tx_comma", comma, m_mode != M_DATA);
         chk("link_up", link_up, m_mode == M_DATA);
         chk("test_pat_active", tp_act, m_tp);
         chk("ltncy_trig", trig, m_trig);
         chk("frm_sep", frm_sep, model_sep());
      end
   end

   task automatic step_to(input int t);
      while (n < t) begin
         @(posedge clk);
         #2;
         n++;
      end
   endtask

   int trig_hits = 0, first_hit = -1, second_hit = -1;

   initial begin
      rst_n = 1; tx_ready = 0; resync = 0; ena_tp = 0; ovf = 0; bc0 = 0;
      #1 rst_n = 0;
      #1 chk_en = 1;
      chk("rst_word_sel", word_sel, 1);
      chk("rst_comma", comma, 1);
      chk("rst_link_up", link_up, 0);
      chk("rst_frm_sep", frm_sep, 8'hBC);
      repeat (3) @(posedge clk);
      #2 rst_n = 1; tx_ready = 1;
      n = -34;
      step_to(-33); @(negedge clk);
      chk("idle_ph0_word_sel", word_sel, 0);
      chk("idle_ph0_comma", comma, 1);
      step_to(-32); @(negedge clk);
      chk("sync_entry_word_sel", word_sel, 1);
      step_to(-1); @(negedge clk);
      chk("last_sync_link_up", link_up, 0);
      step_to(0);
      for (int t = 0; t < 300; t++) begin
         step_to(t);
         @(negedge clk);
         if (t == 0) begin
            chk("data_entry_link_up", link_up, 1);
            chk("data_entry_comma", comma, 0);
         end
         if (trig) begin
            trig_hits++;
            if (trig_hits == 1) first_hit = t;
            else if (trig_hits == 2) second_hit = t;
         end
         if (t % 2 == 1 && t < 18) chk("sep_seq", frm_sep, seq_exp[t / 2]);
      end
      chk("trig_first", first_hit, 1);
      chk("trig_second", second_hit, 257);
      chk("trig_count", trig_hits, 2);

      step_to(301); ovf = 1; @(negedge clk);
      chk("overflow_fc", frm_sep, 8'hFC);
      step_to(302); ovf = 0;
      step_to(303); @(negedge clk);
      chk("after_fc_seq", frm_sep, 8'hFD);
      step_to(305); ovf = 1; bc0 = 1; @(negedge clk);
`ifdef GEM_BC0_MARKER_EN
      chk("bc0_with_ovf", frm_sep, 8'h50);
`else
      chk("bc0_with_ovf", frm_sep, 8'hFC);
`endif
      step_to(306); ovf = 0; bc0 = 0;
      step_to(307); @(negedge clk);
      chk("after_bc0_frame", frm_sep, 8'hBC);

      step_to(309); ena_tp = 1; @(negedge clk);
      chk("tp_p0_same", tp_act, 0);
      step_to(310); @(negedge clk);
      chk("tp_p0_rise", tp_act, 1);
      step_to(311); ena_tp = 0; @(negedge clk);
      chk("tp_hold", tp_act, 1);
      step_to(312); @(negedge clk);
      chk("tp_fall", tp_act, 0);
      step_to(314); ena_tp = 1; @(negedge clk);
      chk("tp_p1_same", tp_act, 0);
      step_to(315); @(negedge clk);
      chk("tp_p1_wait", tp_act, 0);
      step_to(316); @(negedge clk);
      chk("tp_p1_rise", tp_act, 1);

      step_to(318); resync = 1;
      step_to(319); resync = 0; @(negedge clk);
      chk("resync_hold_frame", link_up, 1);
      step_to(320); @(negedge clk);
      chk("resync_link_down", link_up, 0);
      chk("resync_comma", comma, 1);
      step_to(324); resync = 1;
      step_to(325); resync = 0;
      step_to(351); @(negedge clk);
      chk("resync_last_sync", link_up, 0);
      step_to(352); @(negedge clk);
      chk("resync_data_up", link_up, 1);
      chk("resync_sep_bc", frm_sep, 8'hBC);
      step_to(353); @(negedge clk);
      chk("resync_trig", trig, 1);
      step_to(355); @(negedge clk);
      chk("resync_f1_bc", frm_sep, 8'hBC);
      step_to(357); @(negedge clk);
      chk("resync_f2_f7", frm_sep, 8'hF7);

      step_to(360); tx_ready = 0; @(negedge clk);
      chk("rdy_drop_same", link_up, 1);
      step_to(361); @(negedge clk);
      chk("rdy_drop_link", link_up, 0);
      chk("rdy_drop_comma", comma, 1);
      step_to(364); tx_ready = 1;
      step_to(397); @(negedge clk);
      chk("rdy_last_sync", link_up, 0);
      step_to(398); @(negedge clk);
      chk("rdy_data_up", link_up, 1);

      step_to(405);
      #1 rst_n = 0;
      #1;
      chk("midrst_word_sel", word_sel, 1);
      chk("midrst_link_up", link_up, 0);
      chk("midrst_comma", comma, 1);
      chk("midrst_tp", tp_act, 0);
      chk("midrst_trig", trig, 0);
      chk("midrst_sep", frm_sep, 8'hBC);
      @(posedge clk);
      #2 rst_n = 1;
      @(negedge clk);
      chk("post_rst_phase1", word_sel, 1);
      @(negedge clk);
      chk("post_rst_phase0", word_sel, 0);
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
